mont_const_gen: RTL
===================

MONT_CONST_GEN -- requirements
Module: mont_const_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 1024: modulus and result width in bits (legal range 8 to 4096).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 SHALL have port modulus, input, WIDTH bits: divisor M; sampled on the start edge.
REQ-006 SHALL have port r_mod, output, WIDTH bits: 2^WIDTH mod M.
REQ-007 SHALL have port r2_mod, output, WIDTH bits: 2^(2*WIDTH) mod M.
REQ-008 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1 bit: illegal modulus; valid with done.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, FIN; IDLE->RUN on start with legal M; IDLE->FIN on start with illegal M; RUN->FIN after the last iteration; FIN->IDLE unconditionally.
REQ-012 SHALL treat M as illegal when M is even or M equals 1; illegal M -> no iterations, r_mod=r2_mod=0, err=1 with done.
REQ-013 SHALL latch modulus on the start edge; later modulus changes SHALL not affect the running job.
REQ-014 SHALL keep a WIDTH+1-bit accumulator initialised to 1 and perform exactly one step per RUN cycle: acc=2*acc, then subtract M if the result is >= M; acc SHALL stay < M after every step.
REQ-015 SHALL snapshot acc internally after step WIDTH as the R result and SHALL run 2*WIDTH steps in total, with acc after step 2*WIDTH as the R^2 result.
REQ-016 Latency: start high at edge k -> RUN steps on edges k+1..k+2*WIDTH; FIN (done=1) during the cycle after edge k+2*WIDTH; illegal M -> done during the cycle after edge k.
REQ-017 SHALL update r_mod, r2_mod and err only on entry to FIN; they SHALL hold until the next FIN entry.
REQ-018 busy SHALL be 1 in RUN and FIN, and 0 in IDLE.
REQ-019 SHALL ignore start while busy=1; start held high through FIN SHALL be accepted in the following IDLE cycle.
REQ-020 SHALL compute the subtract compare at full WIDTH+1 width; carry out of the WIDTH-bit range SHALL never be dropped.

Reset
REQ-021 rst_n low SHALL force IDLE immediately and clear acc, iteration counter, r_mod, r2_mod, busy, done and err to 0.
REQ-022 Reset mid-RUN SHALL abort the job with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-023 Macro MONT_CONST_R2_EN defined -> SHALL behave as REQ-015/016 with 2*WIDTH steps.
REQ-024 Macro MONT_CONST_R2_EN undefined -> SHALL run WIDTH steps only, done after edge k+WIDTH, and r2_mod SHALL be constant 0.

Structure
REQ-025 Package mont_pkg SHALL hold the FSM state enum and the default-width constant MONT_WIDTH_DEF=1024.
REQ-026 Sub-module mont_dbl_step SHALL be combinational: doubling plus conditional subtract of M, parametrised by WIDTH; it SHALL be the only datapath instance.
REQ-027 The iteration counter SHALL be $clog2(2*WIDTH)+1 bits wide.

Verification
REQ-028 WIDTH=8, M=251, start pulse -> done after 17 cycles, r_mod=5, r2_mod=25, err=0.
REQ-029 WIDTH=8, M=197 -> r_mod=59, r2_mod=132; M=255 -> r_mod=1, r2_mod=1.
REQ-030 WIDTH=8, M=128 (even) and M=1 -> done one cycle after start, err=1, r_mod=r2_mod=0, busy high for exactly one cycle.
REQ-031 WIDTH=8, M=251, start re-pulsed at cycle 5 and modulus changed to 3 mid-run -> results still 5/25, only one done pulse.
REQ-032 rst_n low at cycle 8 of a run -> all outputs 0 immediately, no done; new start with M=3 -> r_mod=1, r2_mod=1.
REQ-033 WIDTH=1024, M = 1024-bit odd test vector, MONT_CONST_R2_EN undefined -> done after 1025 cycles, r_mod matches the golden-model value of 2^1024 mod M, r2_mod=0.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery constant generator.
//   MONT_WIDTH_DEF : default modulus/result width in bits
//   mont_state_e   : control FSM state encoding
package mont_pkg;

  localparam int MONT_WIDTH_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mont_state_e;

endpackage

// File: rtl/mont_dbl_step.sv
// One modular doubling step: acc_out = (2*acc_in) mod M, for acc_in < M.
// Purely combinational.
// Ports:
//   acc_in  [WIDTH:0]   : current accumulator (always < modulus)
//   modulus [WIDTH-1:0] : divisor M
//   acc_out [WIDTH:0]   : doubled accumulator, reduced once by M
module mont_dbl_step #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH:0]   acc_out
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] mod_ext;
  logic           unused_acc_hi;

  // acc_in < M < 2^WIDTH, so its top bit is always zero and the doubled
  // value fits exactly in WIDTH+1 bits; the compare keeps that carry bit.
  assign unused_acc_hi = acc_in[WIDTH];
  assign dbl           = {acc_in[WIDTH-1:0], 1'b0};
  assign mod_ext       = {1'b0, modulus};
  assign acc_out       = (dbl >= mod_ext) ? (dbl - mod_ext) : dbl;

endmodule

// File: rtl/mont_const_gen.sv
// Montgomery constant generator: computes R mod M and R^2 mod M with
// R = 2^WIDTH, by repeated modular doubling of an accumulator starting at 1.
// Optional feature macro: MONT_CONST_R2_EN
//   defined   -> 2*WIDTH steps, r_mod and r2_mod produced
//   undefined -> WIDTH steps, r2_mod tied to 0
// Ports:
//   clk, rst_n (async, active-low)
//   start   : job request, accepted only in IDLE
//   modulus : divisor M, latched on the accepted start edge
//   r_mod   : 2^WIDTH mod M
//   r2_mod  : 2^(2*WIDTH) mod M (0 when the R^2 feature is disabled)
//   busy    : high in RUN and FIN
//   done    : one-cycle pulse in FIN
//   err     : modulus was even or 1; valid with done
module mont_const_gen
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] r_mod,
  output logic [WIDTH-1:0] r2_mod,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef MONT_CONST_R2_EN
  localparam int STEPS = 2 * WIDTH;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int CNT_W = $clog2(2 * WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  mont_state_e      state_q, state_d;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   step_out;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] r_q;
  logic             err_q;
  logic             mod_ok;

  // Legal moduli are odd and greater than 1.
  assign mod_ok = modulus[0] && (modulus != {{(WIDTH-1){1'b0}}, 1'b1});

  mont_dbl_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .modulus (mod_q),
    .acc_out (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = mod_ok ? ST_RUN : ST_FIN;
      ST_RUN:  if (cnt_q == LAST_STEP) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MONT_CONST_R2_EN
  localparam logic [CNT_W-1:0] R_STEP = CNT_W'(WIDTH - 1);
  logic [WIDTH-1:0] r_snap_q;
  logic [WIDTH-1:0] r2_q;
  assign r2_mod = r2_q;
`else
  assign r2_mod = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
`ifdef MONT_CONST_R2_EN
      r_snap_q <= '0;
      r2_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mod_q <= modulus;
            acc_q <= {{WIDTH{1'b0}}, 1'b1};
            cnt_q <= '0;
            // Illegal modulus skips RUN, so results are loaded here on
            // the same edge that enters FIN.
            if (!mod_ok) begin
              r_q   <= '0;
              err_q <= 1'b1;
`ifdef MONT_CONST_R2_EN
              r2_q  <= '0;
`endif
            end
          end
        end
        ST_RUN: begin
          acc_q <= step_out;
          cnt_q <= cnt_q + 1'b1;
`ifdef MONT_CONST_R2_EN
          if (cnt_q == R_STEP) r_snap_q <= step_out[WIDTH-1:0];
`endif
          if (cnt_q == LAST_STEP) begin
            err_q <= 1'b0;
`ifdef MONT_CONST_R2_EN
            r_q   <= r_snap_q;
            r2_q  <= step_out[WIDTH-1:0];
`else
            r_q   <= step_out[WIDTH-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign r_mod = r_q;
  assign err   = err_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FIN);

endmodule
